// File: rtl/pipe_pkg.sv
// Shared constants for the elastic pipeline-stage registers.
// Control-bit indices and per-boundary payload widths.
package pipe_pkg;

   localparam int CTRL_REG_WRITE = 0;
   localparam int CTRL_MEM_REG   = 1;
   localparam int CTRL_MEM_WRITE = 2;
   localparam int CTRL_BRANCH    = 3;
   localparam int CTRL_JAL       = 4;
   localparam int CTRL_JALR      = 5;

   localparam int PIPE_CTRL_W    = 6;

   localparam int DATA_W_IF_ID   = 64;
   localparam int DATA_W_ID_EX   = 229;
   localparam int DATA_W_EX_MEM  = 197;
   localparam int DATA_W_MEM_WB  = 133;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Used for the stage's optional stall/bubble statistics.
module pipe_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready, 2-entry skid, flush.
// Optional stall/bubble counters under PIPE_PERF_CNT_EN.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_EX_MEM,
   parameter int CTRL_W = PIPE_CTRL_W
`ifdef PIPE_PERF_CNT_EN
   ,
   parameter int CNT_W  = 32
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  bubble_cycles
`endif
);

   logic              main_valid;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic              skid_valid;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   logic in_fire;
   logic out_fire;

   assign in_ready  = ~skid_valid & ~reset;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_valid & out_ready;

   assign out_valid = main_valid;
   // Bubbles must never leak side-effecting control bits downstream.
   assign out_ctrl  = main_valid ? main_ctrl : '0;
   assign out_data  = main_data;
   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

   always_ff @(posedge clk) begin
      if (reset) begin
         main_valid <= 1'b0;
         main_ctrl  <= '0;
         main_data  <= '0;
         skid_valid <= 1'b0;
         skid_ctrl  <= '0;
         skid_data  <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid) begin
         if (in_fire) begin
            main_valid <= 1'b1;
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
         end
      end else if (out_fire) begin
         if (skid_valid) begin
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
         end else if (in_fire) begin
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (in_fire) begin
         // Downstream stalled: park the new beat so upstream sees ready late.
         skid_valid <= 1'b1;
         skid_ctrl  <= in_ctrl;
         skid_data  <= in_data;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (main_valid & ~out_ready),
      .count (stall_cycles)
   );

   pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (~main_valid),
      .count (bubble_cycles)
   );
`endif

endmodule
